// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by a word-addressed SRAM with WAIT_STATES wait cycles per transfer.
// Define AHB_SUB_ALIGN_CHECK_EN to turn misaligned or oversize transfers into ERROR responses.
module ahb_sram_subordinate #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LG    = $clog2(NB);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [LG-1:0]         off_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  accept, range_err, err, final_dp;
  logic [2:0]            size_eff;
  logic [NB-1:0]         be;
  logic                  unused_ok;

  function automatic logic [LG-1:0] align_off(input logic [LG-1:0] lo, input logic [2:0] sz);
    logic [LG-1:0] r;
    r = lo;
    for (int b = 0; b < LG; b++)
      if (b < int'(sz)) r[b] = 1'b0;
    return r;
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [LG-1:0] off, input logic [2:0] sz);
    logic [NB-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++)
      if ((b >> sz) == (int'(off) >> sz)) m[b] = 1'b1;
    return m;
  endfunction

  assign unused_ok = ^{HBURST, HTRANS[0]};
  assign size_eff  = (HSIZE > 3'(LG)) ? 3'(LG) : HSIZE;
  assign range_err = (HADDR >> LG) >= ADDR_WIDTH'(MEM_DEPTH);
  // Only IDLE and ERR2 are address-phase-capable cycles for this subordinate
  assign accept    = HSEL & HREADY & HTRANS[1] & ((state_q == S_IDLE) | (state_q == S_ERR2));
  assign final_dp  = (state_q == S_IDLE) & pend_q;
  assign be        = lane_mask(off_q, size_q);

`ifdef AHB_SUB_ALIGN_CHECK_EN
  logic [ADDR_WIDTH-1:0] size_mask;
  assign size_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
  assign err = range_err | (|(HADDR & size_mask)) | (HSIZE > 3'(LG));
`else
  assign err = range_err;
`endif

  assign HREADYOUT = (state_q == S_IDLE) | (state_q == S_ERR2);
  assign HRESP     = (state_q == S_ERR1) | (state_q == S_ERR2);
  assign HRDATA    = (final_dp && !write_q) ? mem[idx_q] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
        if (accept) begin
          if (err) begin
            state_d = S_ERR1;
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              cnt_d   = WS_LOAD;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // The pending write commits on the same edge a pipelined transfer is captured
  always_ff @(posedge HCLK) begin
    if (accept) begin
      write_q <= HWRITE;
      size_q  <= size_eff;
      off_q   <= align_off(HADDR[LG-1:0], size_eff);
      idx_q   <= HADDR[LG +: IDX_W];
    end
    if (final_dp && write_q) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
    end
  end
endmodule
